// File: rtl/chia_xung_pkg.sv
// Shared constants for the programmable multi-channel clock divider.
// Holds parameter limits, the minimum legal period and the select-width helper.
package chia_xung_pkg;

  localparam int MIN_DIV = 2;
  localparam int CH_MIN  = 1;
  localparam int CH_MAX  = 8;
  localparam int W_MIN   = 2;
  localparam int W_MAX   = 32;

  // A single channel still needs a one-bit select port.
  function automatic int ch_sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chia_xung_ch.sv
// One divider channel: active/pending period and high-time, counter, registered q/tick.
// Pending values are promoted only at a period boundary or while the channel is idle.
module chia_xung_ch #(
  parameter int W        = 16,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         wr_en,
  input  logic [W-1:0] wr_div,
  input  logic [W-1:0] wr_high,
  output logic         pend_vld,
  output logic         q,
  output logic         tick
);

  logic [W-1:0] div_q, div_d;
  logic [W-1:0] high_q, high_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic [W-1:0] pend_high_q, pend_high_d;
  logic         pend_vld_q, pend_vld_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;
  logic         q_q, q_d;
  logic         tick_q, tick_d;
  logic         wrap;
  logic         apply;

  // run_q marks that cnt_q holds a live count; the first enabled cycle always starts at cnt=0.
  always_comb begin
    div_d       = div_q;
    high_d      = high_q;
    pend_div_d  = pend_div_q;
    pend_high_d = pend_high_q;
    pend_vld_d  = pend_vld_q;
    run_d       = en;
    cnt_d       = '0;
    wrap        = run_q && (cnt_q == div_q - W'(1));
    apply       = pend_vld_q && (!en || !run_q || wrap);

    if (en && run_q && !wrap) begin
      cnt_d = cnt_q + W'(1);
    end

    if (apply) begin
      div_d      = pend_div_q;
      high_d     = pend_high_q;
      pend_vld_d = 1'b0;
    end else if (wr_en) begin
      pend_div_d  = wr_div;
      pend_high_d = wr_high;
      pend_vld_d  = 1'b1;
    end

    q_d    = en && (cnt_d < high_d);
    tick_d = en && (cnt_d == div_d - W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= W'(DEF_DIV);
      high_q      <= W'(DEF_HIGH);
      pend_div_q  <= W'(DEF_DIV);
      pend_high_q <= W'(DEF_HIGH);
      pend_vld_q  <= 1'b0;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      q_q         <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      high_q      <= high_d;
      pend_div_q  <= pend_div_d;
      pend_high_q <= pend_high_d;
      pend_vld_q  <= pend_vld_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      q_q         <= q_d;
      tick_q      <= tick_d;
    end
  end

  assign pend_vld = pend_vld_q;
  assign q        = q_q;
  assign tick     = tick_q;

endmodule

// File: rtl/chia_xung_prog.sv
// Programmable multi-channel clock divider: configuration decode, legality check,
// ready mux and error pulse around CH independent divider channels.
module chia_xung_prog
  import chia_xung_pkg::*;
#(
  parameter int CH       = 2,
  parameter int W        = 16,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CH-1:0]                 en,
  input  logic                          cfg_we,
  input  logic [ch_sel_width(CH)-1:0]   cfg_ch,
  input  logic [W-1:0]                  cfg_div,
  input  logic [W-1:0]                  cfg_high,
  output logic                          cfg_ready,
  output logic                          cfg_err,
  output logic [CH-1:0]                 q,
  output logic [CH-1:0]                 tick
);

  localparam int CHW = ch_sel_width(CH);

  if (CH < CH_MIN || CH > CH_MAX || W < W_MIN || W > W_MAX) begin : g_bad_param
    $error("chia_xung_prog: CH or W outside supported range");
  end

  logic [CH-1:0] pend_vld;
  logic [CH-1:0] wr_en;
  logic          ch_ok;
  logic          cfg_legal;
  logic          cfg_err_d, cfg_err_q;

  // Out-of-range channel numbers are both not-ready and illegal; illegality wins over ready.
  always_comb begin
    ch_ok     = 1'b0;
    cfg_ready = 1'b0;
    wr_en     = '0;
    for (int i = 0; i < CH; i++) begin
      if (cfg_ch == CHW'(i)) begin
        ch_ok     = 1'b1;
        cfg_ready = !pend_vld[i];
      end
    end
    cfg_legal = ch_ok && (cfg_div >= W'(MIN_DIV)) &&
                (cfg_high != '0) && (cfg_high < cfg_div);
    for (int i = 0; i < CH; i++) begin
      wr_en[i] = cfg_we && cfg_legal && cfg_ready && (cfg_ch == CHW'(i));
    end
    cfg_err_d = cfg_we && !cfg_legal;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    chia_xung_ch #(
      .W        (W),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (en[g]),
      .wr_en    (wr_en[g]),
      .wr_div   (cfg_div),
      .wr_high  (cfg_high),
      .pend_vld (pend_vld[g]),
      .q        (q[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_chia_xung_prog.sv
// Directed self-checking bench for chia_xung_prog (CH=2, W=16, default 2/1 period).
// Channel 1 is never reprogrammed until the last scenario, so its phase follows cyc.
module tb_chia_xung_prog;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  en;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [15:0] cfg_high;
  logic        cfg_ready;
  logic        cfg_err;
  logic [1:0]  q;
  logic [1:0]  tick;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  chia_xung_prog dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .q         (q),
    .tick      (tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_write(input logic we, input logic ch, input logic [15:0] d, input logic [15:0] h);
    cfg_we   = we;
    cfg_ch   = ch;
    cfg_div  = d;
    cfg_high = h;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 2'b00;
    set_write(1'b0, 1'b0, 16'd0, 16'd0);
    step();
    step();
    n_run++; if (q !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_q: got %b expected 00", q); end
    n_run++; if (tick !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_tick: got %b expected 00", tick); end
    n_run++; if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", cfg_err); end
    n_run++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", cfg_ready); end
    reset = 1'b1;
    step();
    n_run++; if (q !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_q: got %b expected 00", q); end
  endtask

  task automatic test_default_toggle();
    en  = 2'b11;
    cyc = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_run++;
      if (q !== ((k % 2 == 0) ? 2'b11 : 2'b00)) begin
        n_fail++; $display("[TB] FAIL default_q k=%0d: got %b expected %b", k, q, (k % 2 == 0) ? 2'b11 : 2'b00);
      end
      n_run++;
      if (tick !== ((k % 2 == 1) ? 2'b11 : 2'b00)) begin
        n_fail++; $display("[TB] FAIL default_tick k=%0d: got %b expected %b", k, tick, (k % 2 == 1) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_update_at_wrap();
    logic eq0, et0, eq1, et1;
    step();
    n_run++; if (q !== 2'b11) begin n_fail++; $display("[TB] FAIL upd_pre_q: got %b expected 11", q); end
    set_write(1'b1, 1'b0, 16'd5, 16'd2);
    n_run++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL upd_ready_before: got %b expected 1", cfg_ready); end
    step();
    cfg_we = 1'b0;
    n_run++; if (q !== 2'b00) begin n_fail++; $display("[TB] FAIL upd_old_period_q: got %b expected 00", q); end
    n_run++; if (tick !== 2'b11) begin n_fail++; $display("[TB] FAIL upd_old_period_tick: got %b expected 11", tick); end
    n_run++; if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL upd_ready_pending: got %b expected 0", cfg_ready); end
    for (int j = 0; j < 10; j++) begin
      step();
      eq0 = ((j % 5) < 2);
      et0 = ((j % 5) == 4);
      eq1 = ((cyc % 2) == 0);
      et1 = ((cyc % 2) == 1);
      n_run++; if (q[0] !== eq0 || tick[0] !== et0) begin
        n_fail++; $display("[TB] FAIL upd_ch0 j=%0d: got q=%b tick=%b expected q=%b tick=%b", j, q[0], tick[0], eq0, et0);
      end
      n_run++; if (q[1] !== eq1 || tick[1] !== et1) begin
        n_fail++; $display("[TB] FAIL upd_ch1 j=%0d: got q=%b tick=%b expected q=%b tick=%b", j, q[1], tick[1], eq1, et1);
      end
      if (j == 0) begin
        n_run++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL upd_ready_after: got %b expected 1", cfg_ready); end
      end
    end
  endtask

  task automatic test_enable_gap();
    logic eq0, et0, eq1, et1;
    step();
    n_run++; if (q[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_cnt0_q: got %b expected 1", q[0]); end
    repeat (3) step();
    n_run++; if (q[0] !== 1'b0 || tick[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL gap_cnt3: got q=%b tick=%b expected q=0 tick=0", q[0], tick[0]);
    end
    en = 2'b10;
    set_write(1'b1, 1'b0, 16'd3, 16'd1);
    step();
    cfg_we = 1'b0;
    eq1 = ((cyc % 2) == 0);
    n_run++; if (q[0] !== 1'b0 || tick[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL gap_off: got q=%b tick=%b expected q=0 tick=0", q[0], tick[0]);
    end
    n_run++; if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_ready_pending: got %b expected 0", cfg_ready); end
    n_run++; if (q[1] !== eq1) begin n_fail++; $display("[TB] FAIL gap_ch1_off: got %b expected %b", q[1], eq1); end
    step();
    n_run++; if (q[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_idle_q: got %b expected 0", q[0]); end
    n_run++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_ready_applied: got %b expected 1", cfg_ready); end
    en = 2'b11;
    for (int k = 0; k < 6; k++) begin
      step();
      eq0 = ((k % 3) == 0);
      et0 = ((k % 3) == 2);
      eq1 = ((cyc % 2) == 0);
      et1 = ((cyc % 2) == 1);
      n_run++; if (q[0] !== eq0 || tick[0] !== et0) begin
        n_fail++; $display("[TB] FAIL gap_ch0 k=%0d: got q=%b tick=%b expected q=%b tick=%b", k, q[0], tick[0], eq0, et0);
      end
      n_run++; if (q[1] !== eq1 || tick[1] !== et1) begin
        n_fail++; $display("[TB] FAIL gap_ch1 k=%0d: got q=%b tick=%b expected q=%b tick=%b", k, q[1], tick[1], eq1, et1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic eq0, et0;
    set_write(1'b1, 1'b0, 16'd4, 16'd3);
    n_run++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready_first: got %b expected 1", cfg_ready); end
    step();
    set_write(1'b1, 1'b0, 16'd2, 16'd1);
    n_run++; if (q[0] !== 1'b1 || tick[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_wrap: got q=%b tick=%b expected q=1 tick=0", q[0], tick[0]);
    end
    n_run++; if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_ready_second: got %b expected 0", cfg_ready); end
    step();
    cfg_we = 1'b0;
    n_run++; if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_silent_drop: got %b expected 0", cfg_err); end
    step();
    n_run++; if (q[0] !== 1'b0 || tick[0] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL b2b_last: got q=%b tick=%b expected q=0 tick=1", q[0], tick[0]);
    end
    set_write(1'b1, 1'b0, 16'd2, 16'd1);
    n_run++; if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_ready_at_wrap: got %b expected 0", cfg_ready); end
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) begin
        cfg_we = 1'b0;
        n_run++; if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_wrap_drop_err: got %b expected 0", cfg_err); end
      end
      eq0 = ((k % 4) < 3);
      et0 = ((k % 4) == 3);
      n_run++; if (q[0] !== eq0 || tick[0] !== et0) begin
        n_fail++; $display("[TB] FAIL b2b_ch0 k=%0d: got q=%b tick=%b expected q=%b tick=%b", k, q[0], tick[0], eq0, et0);
      end
    end
  endtask

  task automatic test_illegal();
    logic eq1, et1;
    set_write(1'b1, 1'b1, 16'd1, 16'd1);
    n_run++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_ready_before: got %b expected 1", cfg_ready); end
    step();
    n_run++; if (cfg_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_div1_err: got %b expected 1", cfg_err); end
    set_write(1'b1, 1'b1, 16'd4, 16'd4);
    step();
    n_run++; if (cfg_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_high_eq_div_err: got %b expected 1", cfg_err); end
    set_write(1'b1, 1'b1, 16'd3, 16'd0);
    step();
    n_run++; if (cfg_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_high0_err: got %b expected 1", cfg_err); end
    cfg_we = 1'b0;
    step();
    n_run++; if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL ill_err_clears: got %b expected 0", cfg_err); end
    n_run++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_no_pending: got %b expected 1", cfg_ready); end
    for (int k = 0; k < 6; k++) begin
      step();
      eq1 = ((cyc % 2) == 0);
      et1 = ((cyc % 2) == 1);
      n_run++; if (q[1] !== eq1 || tick[1] !== et1) begin
        n_fail++; $display("[TB] FAIL ill_ch1 k=%0d: got q=%b tick=%b expected q=%b tick=%b", k, q[1], tick[1], eq1, et1);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_write(1'b1, 1'b1, 16'd6, 16'd3);
    n_run++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_ready_before: got %b expected 1", cfg_ready); end
    step();
    cfg_we = 1'b0;
    n_run++; if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_pending_set: got %b expected 0", cfg_ready); end
    #1 reset = 1'b0;
    #1;
    n_run++; if (q !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_async_q: got %b expected 00", q); end
    n_run++; if (tick !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_async_tick: got %b expected 00", tick); end
    n_run++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pending_cleared: got %b expected 1", cfg_ready); end
    step();
    n_run++; if (q !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_held_q: got %b expected 00", q); end
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_run++;
      if (q !== ((k % 2 == 0) ? 2'b11 : 2'b00) || tick !== ((k % 2 == 1) ? 2'b11 : 2'b00)) begin
        n_fail++; $display("[TB] FAIL rst_resume k=%0d: got q=%b tick=%b expected q=%b tick=%b", k, q, tick,
                           (k % 2 == 0) ? 2'b11 : 2'b00, (k % 2 == 1) ? 2'b11 : 2'b00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_toggle();
    test_update_at_wrap();
    test_enable_gap();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/chia_xung_prog.md
CHIA_XUNG_PROG -- requirements
Module: chia_xung_prog

Interface
REQ-001 Parameter CH, default 2: number of independent divider channels, 1..8.
REQ-002 Parameter W, default 16: width of the period and high-time fields.
REQ-003 Parameter DEF_DIV, default 2: active period of every channel after reset.
REQ-004 Parameter DEF_HIGH, default 1: active high-time of every channel after reset.
REQ-005 clk  input  1: single clock; all state changes on its rising edge.
REQ-006 reset  input  1: asynchronous, active-low reset.
REQ-007 en  input  CH: per-channel run enable, level-sensitive.
REQ-008 cfg_we  input  1: configuration write strobe; one write per asserted cycle.
REQ-009 cfg_ch  input  max(1,$clog2(CH)): target channel of the write.
REQ-010 cfg_div  input  W: requested period in clk cycles.
REQ-011 cfg_high  input  W: requested high-time in clk cycles.
REQ-012 cfg_ready  output  1: high when the addressed channel can accept a write.
REQ-013 cfg_err  output  1: one-cycle pulse when a write is rejected.
REQ-014 q  output  CH: divided clock outputs, registered.
REQ-015 tick  output  CH: one-cycle pulse on the last cycle of each period, registered.

Function
REQ-016 Each channel SHALL hold active (div, high), a pending copy, a pending-valid flag and a counter cnt of width W.
REQ-017 While en[i]=1: cnt SHALL count 0..div-1 and wrap to 0; q[i]=1 when cnt<high, else 0.
REQ-018 tick[i] SHALL be 1 exactly in the cycle cnt==div-1 with en[i]=1.
REQ-019 Output period SHALL be exactly div cycles; the high phase SHALL be exactly high cycles, starting at cnt=0.
REQ-020 A write is legal only if cfg_div>=2, 1<=cfg_high<=cfg_div-1, and cfg_ch<CH.
REQ-021 An illegal write SHALL be discarded, leave all state unchanged and pulse cfg_err the next cycle.
REQ-022 A legal write with cfg_ready=1 SHALL load the pending copy and set pending-valid.
REQ-023 cfg_ready SHALL be 0 while the addressed channel has pending-valid set.
REQ-024 A write with cfg_ready=0 SHALL be discarded silently, without cfg_err.
REQ-025 With en[i]=1, pending values SHALL become active only on the cycle after the cnt==div-1 cycle, with cnt=0; there SHALL be no truncated or stretched period.
REQ-026 With en[i]=0, pending values SHALL become active on the next clock.
REQ-027 Clearing pending-valid SHALL happen in the same edge that applies the pending values.
REQ-028 While en[i]=0: cnt=0, q[i]=0, tick[i]=0.
REQ-029 After en[i] rises, q[i] SHALL be 1 on the next cycle, with cnt=0.
REQ-030 If a wrap and a new write to the same channel coincide, the wrap SHALL apply the old pending values.
REQ-031 The new write in that case SHALL see cfg_ready=0 and be dropped.
REQ-032 Channels SHALL be fully independent; a write to one channel SHALL NOT disturb another.

Reset
REQ-033 On reset low, immediately: q=0, tick=0, cfg_err=0, cnt=0, pending-valid=0, div=DEF_DIV, high=DEF_HIGH.
REQ-034 Reset asserted mid-period or mid-update SHALL discard the pending update.
REQ-035 Reset release SHALL be synchronous in effect: counting resumes on the first clk edge after reset goes high, when en=1.

Structure
REQ-036 Package chia_xung_pkg SHALL hold MIN_DIV=2 and the CH/W limit constants.
REQ-037 A sub-module chia_xung_ch SHALL implement one channel: counter, shadow registers, q/tick.
REQ-038 chia_xung_prog SHALL instantiate chia_xung_ch CH times.
REQ-039 chia_xung_prog SHALL itself contain only the decode, legality check, cfg_ready mux and cfg_err.

Verification
REQ-040 Reset, en=2'b11, no writes -> q toggles every cycle (period 2, high 1); tick high on every odd cycle.
REQ-041 Write ch0 div=5 high=2 mid-period -> current period completes unchanged, then q0 pattern 11000 repeating; tick0 on cnt=4.
REQ-042 Write ch1 div=1, then div=4 high=4 -> cfg_err pulse for each; ch1 output unchanged.
REQ-043 Write ch0 twice before the wrap -> second write sees cfg_ready=0 and is dropped; the first write takes effect.
REQ-044 Deassert en[0] while cnt=3, write div=3 high=1, reassert -> q0 1 on the next cycle, pattern 100, ch1 undisturbed.
REQ-045 Assert reset mid-period with an update pending -> q=0 at once; after release, period=DEF_DIV and the pending update is lost.
